load_writeback_queue: RTL and testbench
=======================================

LOAD_WRITEBACK_QUEUE -- requirements
Module: load_writeback_queue

Interface
REQ-001: The module SHALL have parameter XLEN, default 32, meaning data width.
REQ-002: The module SHALL have parameter DEPTH, default 4, meaning queue entries, a power of two and at least 2.
REQ-003: The module SHALL have parameter NSRC, default 2, meaning forwarding lookup ports.
REQ-004: The module SHALL have parameter AW, default 5, meaning register address width.
REQ-005: The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006: The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007: The module SHALL have ports ld_valid (input, 1), ld_rd (input, AW) and ld_data (input, XLEN), the load-return write request.
REQ-008: The module SHALL have port ld_ready, output, 1 bit, asserted when the queue accepts a push this cycle.
REQ-009: The module SHALL have ports wr_en (output, 1), wr_addr (output, AW) and wr_data (output, XLEN), the register-file write port 4 request.
REQ-010: The module SHALL have port wr_grant, input, 1 bit, write port 4 available this cycle.
REQ-011: The module SHALL have ports src_addr (input, NSRC x AW), fwd_hit (output, NSRC x 1) and fwd_data (output, NSRC x XLEN), the Execute-stage operand lookup.
REQ-012: The module SHALL have ports full (output, 1), empty (output, 1) and count (output, clog2(DEPTH)+1), the occupancy status.

Function
REQ-013: The queue SHALL be a FIFO of {rd, data} entries with head/tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
REQ-014: ld_ready SHALL equal !full; it SHALL NOT depend on wr_grant.
REQ-015: A push SHALL occur when ld_valid && ld_ready; if ld_rd == 0, the request SHALL be accepted and discarded, with no entry and no count change.
REQ-016: wr_en SHALL equal !empty, and wr_addr/wr_data SHALL show the head entry; all three SHALL be combinational from registered state only.
REQ-017: A pop SHALL occur when wr_en && wr_grant, with head advancing by one.
REQ-018: A simultaneous push and pop SHALL leave count unchanged, with both pointers advancing.
REQ-019: When full and a pop occurs, ld_ready SHALL stay 0 in that cycle and the next push SHALL be accepted one cycle later.
REQ-020: The latency from push to earliest wr_en for that entry SHALL be 1 cycle when the queue was empty, with no combinational bypass to wr_*.
REQ-021: For each port i, fwd_hit[i] SHALL be 1 if src_addr[i] != 0 and it matches the incoming accepted push (ld_rd) or any valid queue entry rd.
REQ-022: Forwarding priority SHALL be: incoming push first, then queue entries newest (tail-1) to oldest (head).
REQ-023: fwd_data[i] SHALL be the data of the highest-priority match, and 0 when fwd_hit[i] = 0.
REQ-024: An entry being popped in the current cycle SHALL still be visible to forwarding in that cycle.
REQ-025: Duplicate rd entries SHALL all be retained and written in FIFO order, so the final register value is the newest.
REQ-026: Pushing and popping SHALL be unaffected by stalls or flushes, because entries are committed architectural writes.
REQ-027: full SHALL equal (count == DEPTH), empty SHALL equal (count == 0), and count SHALL never exceed DEPTH or underflow.

Reset
REQ-028: On reset, head, tail and count SHALL become 0, giving empty=1, full=0, ld_ready=1, wr_en=0 and fwd_hit=0 in the following cycle.
REQ-029: Entry storage SHALL NOT be reset; valid data SHALL be derived from count and pointers only.
REQ-030: Reset asserted mid-operation SHALL discard all pending entries, ignore any push or pop in that cycle, and raise no wr_en in the next cycle.

Structure
REQ-031: Shared package skylark_pkg SHALL hold the XLEN and AW defaults and the wbq_entry_t struct {rd, data}.
REQ-032: One sub-module SHALL exist: wbq_fwd_match, a combinational newest-first priority match for one lookup port, instantiated NSRC times.
REQ-033: The design SHALL be synthesisable with no latches, with all state in a single always_ff block.

Verification
REQ-034: After reset, push (rd=3, 0xA5A5A5A5) with wr_grant=0 -> next cycle wr_en=1, wr_addr=3, wr_data=0xA5A5A5A5, count=1.
REQ-035: Fill DEPTH=4 with wr_grant=0 -> full=1, ld_ready=0, and a 5th ld_valid is not accepted; then wr_grant=1 for one cycle -> count=3 and ld_ready=1 in the next cycle.
REQ-036: Queue holds rd=7/0x11 then rd=7/0x22, and an incoming push rd=7/0x33 is applied with src_addr[0]=7 -> fwd_data=0x33; in the next cycle with no push -> 0x33; writes occur in order 0x11, 0x22, 0x33.
REQ-037: Push with rd=0, and src_addr[1]=0 while the queue holds rd=0-free entries -> count unchanged and fwd_hit[1]=0.
REQ-038: Simultaneous push and pop at count=2 with pointers wrapping from 3 to 0 -> count stays 2 and FIFO order is preserved across the wrap.
REQ-039: Assert reset with 3 entries pending -> next cycle empty=1, wr_en=0, fwd_hit=0 on all ports.

Source files
------------

// File: rtl/skylark_pkg.sv
// Shared definitions for the Skylark core writeback path.
package skylark_pkg;

  // Default datapath and register-address widths.
  localparam int unsigned SKY_XLEN = 32;
  localparam int unsigned SKY_AW   = 5;

  // One pending register-file write: destination register and value.
  typedef struct packed {
    logic [SKY_AW-1:0]   rd;
    logic [SKY_XLEN-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Newest-first forwarding match for a single Execute-stage lookup port.
// Entries arrive age-ordered: index 0 is the newest queued write.
module wbq_fwd_match #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5
) (
  input  logic [AW-1:0]              src,
  input  logic                       push_acc,
  input  logic [AW-1:0]              push_rd,
  input  logic [XLEN-1:0]            push_data,
  input  logic [DEPTH-1:0]           ent_vld,
  input  logic [DEPTH-1:0][AW-1:0]   ent_rd,
  input  logic [DEPTH-1:0][XLEN-1:0] ent_data,
  output logic                       hit,
  output logic [XLEN-1:0]            data
);

  // Scan oldest to newest so later (newer) matches override earlier ones,
  // then let the incoming push override everything in the queue.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (src != '0) begin
      for (int unsigned k = DEPTH; k > 0; k--) begin
        if (ent_vld[k-1] && (ent_rd[k-1] == src)) begin
          hit  = 1'b1;
          data = ent_data[k-1];
        end
      end
      if (push_acc && (push_rd == src)) begin
        hit  = 1'b1;
        data = push_data;
      end
    end
  end

endmodule

// File: rtl/load_writeback_queue.sv
// Load-return writeback queue: buffers committed load results until the
// shared register-file write port 4 is granted, and forwards pending
// values to Execute-stage operand lookups.
module load_writeback_queue
  import skylark_pkg::*;
#(
  parameter int unsigned XLEN  = SKY_XLEN,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned AW    = SKY_AW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_valid,
  input  logic [AW-1:0]                ld_rd,
  input  logic [XLEN-1:0]              ld_data,
  output logic                         ld_ready,
  output logic                         wr_en,
  output logic [AW-1:0]                wr_addr,
  output logic [XLEN-1:0]              wr_data,
  input  logic                         wr_grant,
  input  logic [NSRC-1:0][AW-1:0]      src_addr,
  output logic [NSRC-1:0]              fwd_hit,
  output logic [NSRC-1:0][XLEN-1:0]    fwd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage is deliberately not reset; validity comes from count.
  logic [AW-1:0]   mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic push_acc;
  logic push_en;
  logic pop_en;

  // Age-ordered view of the queue for forwarding (index 0 = newest).
  logic [DEPTH-1:0]           age_vld;
  logic [DEPTH-1:0][AW-1:0]   age_rd;
  logic [DEPTH-1:0][XLEN-1:0] age_data;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign ld_ready = !full;

  // rd==0 requests are accepted (handshake completes) but never stored.
  assign push_acc = ld_valid && ld_ready;
  assign push_en  = push_acc && (ld_rd != '0);

  // Write port request comes purely from registered state.
  assign wr_en   = !empty;
  assign wr_addr = mem_rd[head_q];
  assign wr_data = mem_data[head_q];
  assign pop_en  = wr_en && wr_grant;

  // Pointer, occupancy and storage updates; reset drops any push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) begin
        mem_rd[tail_q]   <= ld_rd;
        mem_data[tail_q] <= ld_data;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop_en) begin
        head_q <= head_q + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Rotate storage so the match logic sees entries newest-first; the head
  // entry stays valid during its pop cycle since count has not yet dropped.
  always_comb begin
    logic [PW-1:0] slot;
    slot     = '0;
    age_vld  = '0;
    age_rd   = '0;
    age_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot        = tail_q - PW'(k) - PW'(1);
      age_vld[k]  = (CW'(k) < count_q);
      age_rd[k]   = mem_rd[slot];
      age_data[k] = mem_data[slot];
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    wbq_fwd_match #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_match (
      .src       (src_addr[i]),
      .push_acc  (push_acc),
      .push_rd   (ld_rd),
      .push_data (ld_data),
      .ent_vld   (age_vld),
      .ent_rd    (age_rd),
      .ent_data  (age_data),
      .hit       (fwd_hit[i]),
      .data      (fwd_data[i])
    );
  end

endmodule

// File: tb/tb_load_writeback_queue.sv
// Scoreboard bench for load_writeback_queue: a queue model tracks accepted
// pushes and is popped whenever the DUT's write is granted.
module tb_load_writeback_queue;
  import skylark_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned AW    = 5;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      ld_valid;
  logic [AW-1:0]             ld_rd;
  logic [XLEN-1:0]           ld_data;
  logic                      ld_ready;
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [XLEN-1:0]           wr_data;
  logic                      wr_grant;
  logic [NSRC-1:0][AW-1:0]   src_addr;
  logic [NSRC-1:0]           fwd_hit;
  logic [NSRC-1:0][XLEN-1:0] fwd_data;
  logic                      full;
  logic                      empty;
  logic [$clog2(DEPTH):0]    count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  wbq_entry_t q[$];

  load_writeback_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .NSRC  (NSRC),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_grant (wr_grant),
    .src_addr (src_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected forwarding: last matching queued entry wins, incoming push wins over all.
  function automatic void fwd_model(input logic [AW-1:0] src, input bit acc,
                                    output bit hit, output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (src != '0) begin
      foreach (q[i]) begin
        if (q[i].rd == src) begin
          hit = 1'b1;
          d   = q[i].data;
        end
      end
      if (acc && (ld_rd == src)) begin
        hit = 1'b1;
        d   = ld_data;
      end
    end
  endfunction

  // Check all outputs against the model, clock once, then update the model.
  task automatic cycle();
    bit acc;
    bit h;
    logic [XLEN-1:0] d;
    wbq_entry_t e;
    #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("ld_ready", 64'(ld_ready), 64'(q.size() < DEPTH));
    chk("wr_en", 64'(wr_en), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wr_addr", 64'(wr_addr), 64'(q[0].rd));
      chk("wr_data", 64'(wr_data), 64'(q[0].data));
    end
    acc = ld_valid && (q.size() < DEPTH);
    for (int i = 0; i < NSRC; i++) begin
      fwd_model(src_addr[i], acc, h, d);
      chk("fwd_hit", 64'(fwd_hit[i]), 64'(h));
      chk("fwd_data", 64'(fwd_data[i]), 64'(d));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (wr_grant && (q.size() != 0)) e = q.pop_front();
      if (acc && (ld_rd != '0)) begin
        e.rd   = ld_rd;
        e.data = ld_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    ld_valid = 1'b1;
    ld_rd    = rd;
    ld_data  = data;
    cycle();
    ld_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_rd    = '0;
    ld_data  = '0;
    wr_grant = 1'b0;
    src_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(ld_ready), 64'd1);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    src_addr = {5'd3, 5'd3};
    #1;
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    src_addr = '0;

    // Single push is visible at the write port one cycle later
    push(5'd3, 32'hA5A5_A5A5);
    chk("p1_wr_en", 64'(wr_en), 64'd1);
    chk("p1_wr_addr", 64'(wr_addr), 64'd3);
    chk("p1_wr_data", 64'(wr_data), 64'hA5A5_A5A5);
    chk("p1_count", 64'(count), 64'd1);

    // Fill to DEPTH, reject a 5th push, pop once while full
    for (int unsigned r = 4; r < 7; r++) push(5'(r), 32'h100 + r);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(ld_ready), 64'd0);
    ld_valid = 1'b1;
    ld_rd    = 5'd8;
    ld_data  = 32'h888;
    cycle();
    chk("fill_rejected_count", 64'(count), 64'd4);
    wr_grant = 1'b1;
    cycle();
    wr_grant = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("pop_full_count", 64'(count), 64'd3);
    chk("pop_full_ready", 64'(ld_ready), 64'd1);
    wr_grant = 1'b1;
    repeat (3) cycle();
    wr_grant = 1'b0;

    // Duplicate rd: forwarding prefers push, then newest entry; FIFO write order
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    src_addr[0] = 5'd7;
    ld_valid = 1'b1;
    ld_rd    = 5'd7;
    ld_data  = 32'h33;
    #1;
    chk("dup_fwd_push", 64'(fwd_data[0]), 64'h33);
    cycle();
    ld_valid = 1'b0;
    #1;
    chk("dup_fwd_queue", 64'(fwd_data[0]), 64'h33);
    wr_grant = 1'b1;
    chk("dup_wr0", 64'(wr_data), 64'h11);
    cycle();
    chk("dup_wr1", 64'(wr_data), 64'h22);
    cycle();
    chk("dup_wr2", 64'(wr_data), 64'h33);
    cycle();
    wr_grant = 1'b0;
    src_addr = '0;

    // Simultaneous push/pop at count=2 with both pointers wrapping past 3
    push(5'd10, 32'hA0);
    push(5'd11, 32'hB0);
    chk("wrap_count_pre", 64'(count), 64'd2);
    wr_grant = 1'b1;
    ld_valid = 1'b1;
    ld_rd    = 5'd12;
    ld_data  = 32'hC0;
    cycle();
    ld_valid = 1'b0;
    wr_grant = 1'b0;
    #1;
    chk("wrap_count", 64'(count), 64'd2);
    chk("wrap_head", 64'(wr_addr), 64'd11);
    wr_grant = 1'b1;
    cycle();
    chk("wrap_next", 64'(wr_data), 64'hC0);
    cycle();
    wr_grant = 1'b0;

    // rd=0 push is discarded; lookup of x0 never hits
    push(5'd9, 32'h99);
    src_addr = {5'd0, 5'd9};
    ld_valid = 1'b1;
    ld_rd    = 5'd0;
    ld_data  = 32'hDEAD;
    #1;
    chk("x0_fwd_hit1", 64'(fwd_hit[1]), 64'd0);
    chk("x0_fwd_data0", 64'(fwd_data[0]), 64'h99);
    cycle();
    ld_valid = 1'b0;
    #1;
    chk("x0_count", 64'(count), 64'd1);
    wr_grant = 1'b1;
    cycle();
    wr_grant = 1'b0;

    // Reset with entries pending, while a push and pop are also requested
    push(5'd1, 32'h1);
    push(5'd2, 32'h2);
    push(5'd3, 32'h3);
    src_addr = {5'd3, 5'd1};
    ld_valid = 1'b1;
    ld_rd    = 5'd4;
    ld_data  = 32'h4;
    wr_grant = 1'b1;
    reset    = 1'b1;
    cycle();
    reset    = 1'b0;
    ld_valid = 1'b0;
    wr_grant = 1'b0;
    #1;
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_wr_en", 64'(wr_en), 64'd0);
    chk("mrst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);

    // Randomised traffic with a small rd range to force duplicates
    for (int n = 0; n < 400; n++) begin
      ld_valid    = ($urandom_range(0, 1) == 1);
      ld_rd       = 5'($urandom_range(0, 3));
      ld_data     = $urandom;
      wr_grant    = ($urandom_range(0, 2) != 0);
      src_addr[0] = 5'($urandom_range(0, 3));
      src_addr[1] = 5'($urandom_range(0, 3));
      reset       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset    = 1'b0;
    ld_valid = 1'b0;
    wr_grant = 1'b1;
    repeat (DEPTH + 1) cycle();
    chk("final_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
